// File: rtl/rf_pkg.sv
// Shared defaults and write-priority resolution for the multiport register file.
package rf_pkg;

    localparam int unsigned RF_DATA_W   = 32;
    localparam int unsigned RF_NUM_REGS = 16;
    localparam int unsigned RF_PC_IDX   = RF_NUM_REGS - 1;
    localparam int unsigned RF_PC_STEP  = 4;

    typedef enum logic [1:0] {
        WR_NONE,
        WR_PORT0,
        WR_PORT1
    } wr_sel_e;

    // Which write port (if any) owns a given register address this cycle; port 0 wins ties.
    function automatic wr_sel_e wr_resolve(
        input logic [15:0] addr,
        input logic        e0,
        input logic [15:0] rw0,
        input logic        e1,
        input logic [15:0] rw1
    );
        wr_sel_e sel;
        sel = WR_NONE;
        if (e0 && (rw0 == addr)) begin
            sel = WR_PORT0;
        end else if (e1 && (rw1 == addr)) begin
            sel = WR_PORT1;
        end
        return sel;
    endfunction

endpackage

// File: rtl/register_file_multiport_rf_read_port.sv
// One combinational read port: register select mux with optional write bypass.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned NUM_REGS = RF_NUM_REGS,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic [DATA_W-1:0] regs_i [NUM_REGS],
    input  logic              bypass_en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              e0_i,
    input  logic [ADDR_W-1:0] rw0_i,
    input  logic [DATA_W-1:0] pw0_i,
    input  logic              e1_i,
    input  logic [ADDR_W-1:0] rw1_i,
    input  logic [DATA_W-1:0] pw1_i,
    output logic [DATA_W-1:0] data_o
);

    always_comb begin
        data_o = regs_i[addr_i];
        if (bypass_en_i) begin
            case (wr_resolve(16'(addr_i), e0_i, 16'(rw0_i), e1_i, 16'(rw1_i)))
                WR_PORT0: data_o = pw0_i;
                WR_PORT1: data_o = pw1_i;
                default:  data_o = regs_i[addr_i];
            endcase
        end
    end

endmodule

// File: rtl/register_file_multiport.sv
// Parametrised dual-write, multi-read register file with auto-incrementing PC register.
module register_file_multiport
    import rf_pkg::*;
#(
    parameter int unsigned       DATA_W   = RF_DATA_W,
    parameter int unsigned       NUM_REGS = RF_NUM_REGS,
    parameter int unsigned       ADDR_W   = $clog2(NUM_REGS),
    parameter int unsigned       NUM_RD   = 3,
    parameter int unsigned       PC_IDX   = NUM_REGS - 1,
    parameter int unsigned       PC_STEP  = RF_PC_STEP,
    parameter logic [DATA_W-1:0] PC_RESET = '0,
    parameter bit                BYPASS   = 1'b1
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic [DATA_W-1:0]        PW0,
    input  logic [ADDR_W-1:0]        RW0,
    input  logic                     E0,
    input  logic [DATA_W-1:0]        PW1,
    input  logic [ADDR_W-1:0]        RW1,
    input  logic                     E1,
    input  logic                     PC_INC,
    input  logic [NUM_RD*ADDR_W-1:0] RA,
    output logic [NUM_RD*DATA_W-1:0] PD,
    output logic [DATA_W-1:0]        PC_OUT
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              bypass_en;

    // Explicit writes to the PC take priority over the auto-increment.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            case (wr_resolve(16'(i), E0, 16'(RW0), E1, 16'(RW1)))
                WR_PORT0: regs_d[i] = PW0;
                WR_PORT1: regs_d[i] = PW1;
                default: begin
                    if ((i == PC_IDX) && PC_INC) begin
                        regs_d[i] = regs_q[i] + DATA_W'(PC_STEP);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == PC_IDX) ? PC_RESET : '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign PC_OUT = regs_q[PC_IDX];

    // Bypass is masked while reset is held so reads show the cleared contents.
    assign bypass_en = BYPASS && RESET_N;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        rf_read_port #(
            .DATA_W   (DATA_W),
            .NUM_REGS (NUM_REGS),
            .ADDR_W   (ADDR_W)
        ) u_rd (
            .regs_i      (regs_q),
            .bypass_en_i (bypass_en),
            .addr_i      (RA[k*ADDR_W +: ADDR_W]),
            .e0_i        (E0),
            .rw0_i       (RW0),
            .pw0_i       (PW0),
            .e1_i        (E1),
            .rw1_i       (RW1),
            .pw1_i       (PW1),
            .data_o      (PD[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_register_file_multiport.sv
// Randomised and directed check of register_file_multiport (bypass and no-bypass builds).
module tb_register_file_multiport;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [31:0] PW0, PW1;
    logic [3:0]  RW0, RW1;
    logic        E0, E1, PC_INC;
    logic [11:0] RA;
    logic [95:0] pd_b, pd_n;
    logic [31:0] pc_b, pc_n;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [31:0] m [16];

    always #5 CLK = ~CLK;

    register_file_multiport #(.BYPASS(1'b1)) u_dut_byp (
        .CLK(CLK), .RESET_N(RESET_N),
        .PW0(PW0), .RW0(RW0), .E0(E0),
        .PW1(PW1), .RW1(RW1), .E1(E1),
        .PC_INC(PC_INC), .RA(RA), .PD(pd_b), .PC_OUT(pc_b)
    );

    register_file_multiport #(.BYPASS(1'b0)) u_dut_nobyp (
        .CLK(CLK), .RESET_N(RESET_N),
        .PW0(PW0), .RW0(RW0), .E0(E0),
        .PW1(PW1), .RW1(RW1), .E1(E1),
        .PC_INC(PC_INC), .RA(RA), .PD(pd_n), .PC_OUT(pc_n)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] ra3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        return {c, b, a};
    endfunction

    // Expected read: with bypass, the value the register is about to hold from this cycle's writes.
    function automatic logic [31:0] exp_read(input logic [3:0] a, input bit bp);
        logic [31:0] t [16];
        t = m;
        if (bp && RESET_N) begin
            if (E1) t[RW1] = PW1;
            if (E0) t[RW0] = PW0;
        end
        return t[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m[i] = 32'h0;
    endtask

    task automatic model_clock();
        logic [31:0] nx [16];
        nx = m;
        if (PC_INC) nx[15] = m[15] + 32'd4;
        if (E1) nx[RW1] = PW1;
        if (E0) nx[RW0] = PW0;
        m = nx;
    endtask

    task automatic check_reads();
        for (int k = 0; k < 3; k++) begin
            logic [3:0] a;
            a = RA[k*4 +: 4];
            check_eq($sformatf("byp_rd%0d_r%0d", k, a), pd_b[k*32 +: 32], exp_read(a, 1'b1));
            check_eq($sformatf("nobyp_rd%0d_r%0d", k, a), pd_n[k*32 +: 32], exp_read(a, 1'b0));
        end
        check_eq("byp_pc_out", pc_b, m[15]);
        check_eq("nobyp_pc_out", pc_n, m[15]);
    endtask

    task automatic tick(input logic e0, input logic [3:0] rw0, input logic [31:0] pw0,
                        input logic e1, input logic [3:0] rw1, input logic [31:0] pw1,
                        input logic inc, input logic [11:0] ra);
        E0 = e0; RW0 = rw0; PW0 = pw0;
        E1 = e1; RW1 = rw1; PW1 = pw1;
        PC_INC = inc; RA = ra;
        #1;
        check_reads();
        @(posedge CLK);
        if (RESET_N) model_clock();
        @(negedge CLK);
    endtask

    task automatic idle(input logic [11:0] ra);
        tick(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, ra);
    endtask

    initial begin
        RESET_N = 1'b0;
        E0 = 1'b0; E1 = 1'b0; PC_INC = 1'b0;
        RW0 = '0; RW1 = '0; PW0 = '0; PW1 = '0; RA = '0;
        model_reset();
        #2;
        for (int a = 0; a < 16; a++) begin
            RA = ra3(4'(a), 4'(a), 4'(a));
            #1;
            check_reads();
        end
        check_eq("reset_pc_const", pc_b, 32'h0);
        @(negedge CLK);
        RESET_N = 1'b1;

        // Dual write to distinct registers, then same-address collision.
        tick(1'b1, 4'd3, 32'hDEADBEEF, 1'b1, 4'd5, 32'h12345678, 1'b0, ra3(4'd3, 4'd5, 4'd7));
        tick(1'b1, 4'd7, 32'hAAAA0000, 1'b1, 4'd7, 32'h5555FFFF, 1'b0, ra3(4'd3, 4'd5, 4'd7));
        RA = ra3(4'd7, 4'd3, 4'd5);
        #1;
        check_eq("r7_port0_wins", pd_n[31:0], 32'hAAAA0000);
        check_eq("r3_stored", pd_n[63:32], 32'hDEADBEEF);
        check_eq("r5_stored", pd_n[95:64], 32'h12345678);

        // PC auto-increment, write-over-increment priority, wrap.
        repeat (3) tick(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, ra3(4'd15, 4'd15, 4'd15));
        #1;
        check_eq("pc_after_3_inc", pc_b, 32'd12);
        tick(1'b0, 4'd0, 32'h0, 1'b1, 4'd15, 32'h100, 1'b1, ra3(4'd15, 4'd0, 4'd1));
        #1;
        check_eq("pc_write_beats_inc", pc_b, 32'h100);
        tick(1'b1, 4'd15, 32'hFFFFFFFC, 1'b0, 4'd0, 32'h0, 1'b0, ra3(4'd15, 4'd15, 4'd2));
        tick(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, ra3(4'd15, 4'd15, 4'd2));
        #1;
        check_eq("pc_wrap", pc_b, 32'h0);

        // No-bypass build sees the old value during the write cycle.
        tick(1'b1, 4'd2, 32'h11, 1'b0, 4'd0, 32'h0, 1'b0, ra3(4'd2, 4'd2, 4'd2));
        #1;
        check_eq("nobyp_r2_next", pd_n[31:0], 32'h11);

        // Reset asserted mid-cycle over a pending write, then the first write after release.
        E0 = 1'b1; RW0 = 4'd4; PW0 = 32'hFF; E1 = 1'b0; PC_INC = 1'b1;
        RA = ra3(4'd4, 4'd4, 4'd15);
        #2;
        RESET_N = 1'b0;
        model_reset();
        #1;
        check_reads();
        check_eq("reset_r4_no_bypass", pd_b[31:0], 32'h0);
        @(posedge CLK);
        #2;
        RESET_N = 1'b1;
        @(negedge CLK);
        tick(1'b1, 4'd4, 32'hFF, 1'b0, 4'd0, 32'h0, 1'b0, ra3(4'd4, 4'd4, 4'd15));
        #1;
        check_eq("r4_after_reset_write", pd_n[31:0], 32'hFF);

        for (int n = 0; n < 400; n++) begin
            tick(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                 1'($urandom_range(0, 1)), 12'($urandom));
        end
        idle(ra3(4'd15, 4'd0, 4'd8));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
